// File: rtl/baud_sched.sv
// Round-robin scheduler sharing one baud tick generator between NREQ serializers.
// Optional BAUD_SCHED_SKIP_SAME_RATE_EN: same-rate grants skip the generator restart.
module baud_sched #(
  parameter int NREQ = 2,
  parameter int LENW = 8
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    rate,
  input  logic [LENW*NREQ-1:0] len,
  input  logic                 tick_in,
  output logic [1:0]           gen_ctrl,
  output logic                 gen_rst_n,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      tick_out,
  output logic [NREQ-1:0]      done,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SWITCH, RUN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        gen_ctrl_q, gen_ctrl_d;
  logic              gen_rst_n_q, gen_rst_n_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [LENW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     win_q, win_d;

  logic [IW-1:0]     pick;
  logic              found;
  logic [1:0]        pick_rate;
  logic [LENW-1:0]   pick_len;
  logic              skip_switch;

  // Search starts just after the previous winner so a requester that keeps
  // req high is re-granted only when nobody else is waiting.
  always_comb begin
    int idx;
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign pick_rate = rate[2*pick +: 2];
  assign pick_len  = (len[LENW*pick +: LENW] == '0) ? LENW'(1) : len[LENW*pick +: LENW];

`ifdef BAUD_SCHED_SKIP_SAME_RATE_EN
  assign skip_switch = (pick_rate == gen_ctrl_q);
`else
  assign skip_switch = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gen_ctrl_d  = gen_ctrl_q;
    gen_rst_n_d = 1'b1;
    grant_d     = grant_q;
    done_d      = '0;
    cnt_d       = cnt_q;
    last_d      = last_q;
    win_d       = win_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          win_d         = pick;
          gen_ctrl_d    = pick_rate;
          cnt_d         = pick_len;
          if (skip_switch) begin
            state_d = RUN;
          end else begin
            state_d     = SWITCH;
            gen_rst_n_d = 1'b0;
          end
        end
      end
      SWITCH: state_d = RUN;
      RUN: begin
        // Losing the request wins over a coincident final tick: no done.
        if (!req[win_q]) begin
          grant_d = '0;
          last_d  = win_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (tick_in) begin
          if (cnt_q == LENW'(1)) begin
            done_d[win_q] = 1'b1;
            grant_d       = '0;
            last_d        = win_q;
            cnt_d         = '0;
            state_d       = IDLE;
          end else begin
            cnt_d = cnt_q - LENW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= IDLE;
      gen_ctrl_q  <= 2'b00;
      gen_rst_n_q <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      cnt_q       <= '0;
      last_q      <= IW'(NREQ - 1);
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      gen_ctrl_q  <= gen_ctrl_d;
      gen_rst_n_q <= gen_rst_n_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      win_q       <= win_d;
    end
  end

  assign gen_ctrl  = gen_ctrl_q;
  assign gen_rst_n = gen_rst_n_q;
  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign tick_out  = grant_q & {NREQ{tick_in && (state_q == RUN)}};

endmodule

// File: tb/tb_baud_sched.sv
// Directed bench for baud_sched (NREQ=2, LENW=8); ticks are driven by hand.
module tb_baud_sched;
  logic        Clk = 1'b0;
  logic        ResetN;
  logic [1:0]  req;
  logic [3:0]  rate;
  logic [15:0] len;
  logic        tick_in;
  logic [1:0]  gen_ctrl;
  logic        gen_rst_n;
  logic [1:0]  grant;
  logic [1:0]  tick_out;
  logic [1:0]  done;
  logic        busy;

  int n_pass = 0;
  int n_chk  = 0;

`ifdef BAUD_SCHED_SKIP_SAME_RATE_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  baud_sched #(.NREQ(2), .LENW(8)) dut (
    .Clk(Clk), .ResetN(ResetN), .req(req), .rate(rate), .len(len),
    .tick_in(tick_in), .gen_ctrl(gen_ctrl), .gen_rst_n(gen_rst_n),
    .grant(grant), .tick_out(tick_out), .done(done), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Grant edge; same=1 means the winner's rate equals the current gen_ctrl.
  task automatic grant_seq(input logic [1:0] eg, input logic [1:0] ectrl, input bit same);
    step();
    check("grant", grant, eg);
    check("gen_ctrl", gen_ctrl, ectrl);
    check("busy_grant", busy, 1);
    if (same && SKIP_EN) begin
      check("rstn_kept", gen_rst_n, 1);
    end else begin
      check("rstn_pulse", gen_rst_n, 0);
      tick_in = 1'b1;
      #1 check("switch_tick_blocked", tick_out, 0);
      step();
      tick_in = 1'b0;
      check("rstn_up", gen_rst_n, 1);
    end
    $display("grant %b ctrl %b at %0t", grant, gen_ctrl, $time);
  endtask

  task automatic do_tick(input logic [1:0] eout, input logic [1:0] edone, input logic [1:0] egrant);
    step();
    step();
    tick_in = 1'b1;
    #1 check("tick_out", tick_out, eout);
    step();
    tick_in = 1'b0;
    check("done", done, edone);
    check("grant_after_tick", grant, egrant);
    $display("tick out=%b done=%b grant=%b at %0t", eout, done, grant, $time);
  endtask

  initial begin
    ResetN = 1'b0; req = '0; rate = '0; len = '0; tick_in = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_gen_ctrl", gen_ctrl, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_rstn", gen_rst_n, 0);
    check("rst_done", done, 0);
    ResetN = 1'b1;
    step();
    check("rstn_release", gen_rst_n, 1);
    check("idle_busy", busy, 0);

    // Single request, 3 ticks
    req = 2'b01; rate = 4'b0011; len = {8'd0, 8'd3};
    grant_seq(2'b01, 2'b11, 1'b0);
    do_tick(2'b01, 2'b00, 2'b01);
    do_tick(2'b01, 2'b00, 2'b01);
    do_tick(2'b01, 2'b01, 2'b00);
    check("single_busy_drop", busy, 0);
    req = 2'b00;
    step();
    check("done_one_cycle", done, 0);
    check("ctrl_hold_idle", gen_ctrl, 2'b11);

    // Round robin: last winner was 0, so requester 1 goes first
    req = 2'b11; rate = 4'b1111; len = {8'd2, 8'd2};
    grant_seq(2'b10, 2'b11, 1'b1);
    do_tick(2'b10, 2'b00, 2'b10);
    do_tick(2'b10, 2'b10, 2'b00);
    check("rr_idle_gap", busy, 0);
    grant_seq(2'b01, 2'b11, 1'b1);
    do_tick(2'b01, 2'b00, 2'b01);
    do_tick(2'b01, 2'b01, 2'b00);
    grant_seq(2'b10, 2'b11, 1'b1);
    do_tick(2'b10, 2'b00, 2'b10);
    do_tick(2'b10, 2'b10, 2'b00);

    // Abort requester 0 after 1 of 4 ticks; requester 1 (len 0) pending
    len = {8'd0, 8'd4};
    grant_seq(2'b01, 2'b11, 1'b1);
    do_tick(2'b01, 2'b00, 2'b01);
    req = 2'b10;
    step();
    check("abort_grant", grant, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    grant_seq(2'b10, 2'b11, 1'b1);
    do_tick(2'b10, 2'b10, 2'b00);

    // len0 = 0 at a new rate: exactly one tick
    req = 2'b01; rate = 4'b1101; len = {8'd0, 8'd0};
    grant_seq(2'b01, 2'b01, 1'b0);
    do_tick(2'b01, 2'b01, 2'b00);

    // Abort coincident with final tick: no done
    len = {8'd0, 8'd1};
    grant_seq(2'b01, 2'b01, 1'b1);
    step();
    req = 2'b00; tick_in = 1'b1;
    #1 check("final_tick_fwd", tick_out, 2'b01);
    step();
    tick_in = 1'b0;
    check("abort_prio_done", done, 0);
    check("abort_prio_grant", grant, 0);
    step();
    check("abort_prio_no_late_done", done, 0);
    check("ctrl_hold_after", gen_ctrl, 2'b01);

    // Asynchronous reset mid-burst
    req = 2'b01; len = {8'd0, 8'd5};
    step();
    check("pre_reset_busy", busy, 1);
    ResetN = 1'b0;
    #1;
    check("async_grant", grant, 0);
    check("async_busy", busy, 0);
    check("async_ctrl", gen_ctrl, 0);
    check("async_rstn", gen_rst_n, 0);
    check("async_done", done, 0);
    req = 2'b00;
    @(negedge Clk);
    ResetN = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
